// File: rtl/gost_28147_89_gamma.sv
// GOST 28147-89 gamma (counter) mode controller wrapped around an external block core.
// Optional macro GOST_GAMMA_PREFETCH_EN adds a 1-entry gamma buffer computed ahead of demand.
module gost_28147_89_gamma #(
    parameter logic [31:0] C1 = 32'h01010104,
    parameter logic [31:0] C2 = 32'h01010101
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] iv,
    output logic        busy,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        core_mode,
    output logic        core_load,
    output logic [63:0] core_pdata,
    input  logic        core_done,
    input  logic [63:0] core_cdata
);
    typedef enum logic [2:0] {IDLE, SYNC_LD, SYNC_WAIT, STEP, GAM_WAIT, OUT} state_t;

    state_t      state;
    logic [31:0] n3, n4;
    logic [31:0] n3_next, n4_next;
    logic [32:0] n4_sum;
    logic        done_ok;

    assign core_mode = 1'b0;
    assign n3_next   = n3 + C2;
    assign n4_sum    = {1'b0, n4} + {1'b0, C1};
    // End-around carry gives addition mod 2^32-1; 32'hFFFFFFFF survives as a legal value.
    assign n4_next   = n4_sum[31:0] + {31'd0, n4_sum[32]};
    // A done coinciding with our own load belongs to the previous run.
    assign done_ok   = core_done & ~core_load;

`ifndef GOST_GAMMA_PREFETCH_EN
    logic [63:0] data_latch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            core_load  <= 1'b0;
            core_pdata <= '0;
            out_data   <= '0;
            n3         <= '0;
            n4         <= '0;
            data_latch <= '0;
        end else begin
            core_load <= 1'b0;
            if (start) begin
                state      <= SYNC_LD;
                core_pdata <= iv;
                core_load  <= 1'b1;
                busy       <= 1'b1;
                in_ready   <= 1'b0;
                out_valid  <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    SYNC_LD: state <= SYNC_WAIT;
                    SYNC_WAIT: if (done_ok) begin
                        n3       <= core_cdata[31:0];
                        n4       <= core_cdata[63:32];
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= STEP;
                    end
                    STEP: if (in_valid && in_ready) begin
                        data_latch <= in_data;
                        n3         <= n3_next;
                        n4         <= n4_next;
                        core_pdata <= {n4_next, n3_next};
                        core_load  <= 1'b1;
                        in_ready   <= 1'b0;
                        state      <= GAM_WAIT;
                    end
                    GAM_WAIT: if (done_ok) begin
                        out_data  <= data_latch ^ core_cdata;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                    OUT: if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= STEP;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
`else
    // OUT here means "gamma buffered"; the next core run starts whenever the buffer empties.
    logic [63:0] gamma;

    assign in_ready = (state == OUT) && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            core_load  <= 1'b0;
            core_pdata <= '0;
            out_data   <= '0;
            n3         <= '0;
            n4         <= '0;
            gamma      <= '0;
        end else begin
            core_load <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (start) begin
                state      <= SYNC_LD;
                core_pdata <= iv;
                core_load  <= 1'b1;
                busy       <= 1'b1;
                out_valid  <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    SYNC_LD: state <= SYNC_WAIT;
                    SYNC_WAIT: if (done_ok) begin
                        n3    <= core_cdata[31:0];
                        n4    <= core_cdata[63:32];
                        busy  <= 1'b0;
                        state <= STEP;
                    end
                    STEP: begin
                        n3         <= n3_next;
                        n4         <= n4_next;
                        core_pdata <= {n4_next, n3_next};
                        core_load  <= 1'b1;
                        state      <= GAM_WAIT;
                    end
                    GAM_WAIT: if (done_ok) begin
                        gamma <= core_cdata;
                        state <= OUT;
                    end
                    OUT: if (in_valid && in_ready) begin
                        out_data  <= in_data ^ gamma;
                        out_valid <= 1'b1;
                        state     <= STEP;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
`endif

endmodule
